// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Purpose : Groups the CPU data-port and Memory data-port signals of the store
//           buffer into one bundle.
// Signals : cpu_addr/cpu_wdata/cpu_read/cpu_write  CPU request (to buffer)
//           cpu_rdata/cpu_stall                    CPU response (from buffer)
//           mem_addr/mem_wdata/mem_read/mem_write  Memory request (from buffer)
//           mem_rdata                              combinational Memory data
//           count/full/empty                       buffer occupancy status
// Modports: slave  - the store buffer itself
//           master - the CPU/Memory environment around it
// -----------------------------------------------------------------------------
interface store_buffer_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata,
    output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_read, mem_write,
           count, full, empty
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_read, mem_write,
           count, full, empty
  );
endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Purpose : Write buffer between a CPU data port and Memory. Stores are queued
//           in a circular FIFO of {addr, data} entries and drained to Memory
//           one per idle cycle, oldest first. Loads that miss the buffer go
//           straight to Memory with zero latency.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-low reset (clears pointers and count)
//           bus  - store_buffer_if.slave (CPU side, Memory side, occupancy)
// Param   : DEPTH - number of FIFO entries, power of two in 2..16
// Option  : STORE_BUFFER_FWD_EN - when defined, a load that hits a buffered
//           address is answered from the youngest matching entry. When not
//           defined, such a load stalls while the head drains until no entry
//           matches, then it is served from Memory.
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  ptr_t        headPtr_q, headPtr_d;
  ptr_t        tailPtr_q, tailPtr_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] entryAddr_q [DEPTH];
  logic [31:0] entryData_q [DEPTH];

  logic        full, empty;
  logic        hit;
  logic        enq, pop;
  logic        stallRaw, memRdRaw, memWrRaw;
  logic [31:0] rdata;
`ifdef STORE_BUFFER_FWD_EN
  logic [31:0] hitData;
`endif

  assign full  = (count_q == 5'(DEPTH));
  assign empty = (count_q == 5'd0);

  // Scan valid entries oldest to youngest so the last match is the youngest.
  always_comb begin
    hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    hitData = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((5'(k) < count_q) &&
          (entryAddr_q[headPtr_q + ptr_t'(k)] == bus.cpu_addr)) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        hitData = entryData_q[headPtr_q + ptr_t'(k)];
`endif
      end
    end
  end

  // A read takes priority over a simultaneous write; the write is dropped.
  always_comb begin
    enq      = 1'b0;
    pop      = 1'b0;
    stallRaw = 1'b0;
    memRdRaw = 1'b0;
    memWrRaw = 1'b0;
    rdata    = bus.mem_rdata;
    if (bus.cpu_read) begin
      if (hit) begin
`ifdef STORE_BUFFER_FWD_EN
        rdata = hitData;
`else
        // Drain the head so the conflicting store reaches Memory first.
        stallRaw = 1'b1;
        memWrRaw = 1'b1;
        pop      = 1'b1;
`endif
      end else begin
        memRdRaw = 1'b1;
      end
    end else if (bus.cpu_write) begin
      if (full) begin
        stallRaw = 1'b1;
      end else begin
        enq = 1'b1;
      end
    end else if (!empty) begin
      memWrRaw = 1'b1;
      pop      = 1'b1;
    end
  end

  always_comb begin
    headPtr_d = pop ? headPtr_q + ptr_t'(1) : headPtr_q;
    tailPtr_d = enq ? tailPtr_q + ptr_t'(1) : tailPtr_q;
    count_d   = count_q + {4'd0, enq} - {4'd0, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage is not reset; only entries below count are ever used.
  always_ff @(posedge clk) begin
    if (enq) begin
      entryAddr_q[tailPtr_q] <= bus.cpu_addr;
      entryData_q[tailPtr_q] <= bus.cpu_wdata;
    end
  end

  // Strobes are gated by rst so a request held during reset reaches nothing.
  assign bus.cpu_stall = rst & stallRaw;
  assign bus.mem_read  = rst & memRdRaw;
  assign bus.mem_write = rst & memWrRaw;
  assign bus.mem_addr  = bus.mem_read  ? bus.cpu_addr :
                         bus.mem_write ? entryAddr_q[headPtr_q] : 32'd0;
  assign bus.mem_wdata = bus.mem_write ? entryData_q[headPtr_q] : 32'd0;
  assign bus.cpu_rdata = rdata;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed bench for store_buffer. A queue-based model of the buffer and an
// array model of Memory predict every output on each falling clock edge;
// literal expectations at chosen points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if sbIf();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sbIf)
  );

  // Memory seen by the DUT, and the Memory contents the model expects.
  logic [31:0] memArr [256];
  logic [31:0] expMem [256];

  assign sbIf.mem_rdata = memArr[sbIf.mem_addr[7:0]];

  always @(posedge clk) begin
    if (sbIf.mem_write) memArr[sbIf.mem_addr[7:0]] = sbIf.mem_wdata;
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } entry_t;

  entry_t q[$];
  int assertCount = 0;
  int errCount    = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
               name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    sbIf.cpu_read  = rd;
    sbIf.cpu_write = wr;
    sbIf.cpu_addr  = addr;
    sbIf.cpu_wdata = data;
    #1;
  endtask

  // Reset throws away everything the model has buffered.
  always @(negedge rst) q.delete();

  logic [31:0] eRdata, eAddr, eWdata, hitData;
  logic        eStall, eMr, eMw, mEnq, mPop, mHit;

  always @(negedge clk) begin
    eStall = 1'b0; eMr = 1'b0; eMw = 1'b0;
    eAddr  = 32'd0; eWdata = 32'd0;
    mEnq   = 1'b0; mPop = 1'b0; mHit = 1'b0; hitData = 32'd0;
    eRdata = 32'd0;
    if (rst === 1'b1) begin
      foreach (q[i]) begin
        if (q[i].a == sbIf.cpu_addr) begin
          mHit = 1'b1;
          hitData = q[i].d;
        end
      end
      if (sbIf.cpu_read && mHit && FWD) begin
        eRdata = hitData;
      end else if (sbIf.cpu_read && mHit) begin
        eStall = 1'b1; eMw = 1'b1; mPop = 1'b1;
        eAddr = q[0].a; eWdata = q[0].d;
      end else if (sbIf.cpu_read) begin
        eMr = 1'b1; eAddr = sbIf.cpu_addr;
      end else if (sbIf.cpu_write) begin
        if (q.size() == DEPTH) eStall = 1'b1;
        else mEnq = 1'b1;
      end else if (q.size() > 0) begin
        eMw = 1'b1; mPop = 1'b1;
        eAddr = q[0].a; eWdata = q[0].d;
      end
    end
    if (!(sbIf.cpu_read && mHit && FWD && rst === 1'b1)) begin
      eRdata = eMr ? expMem[eAddr[7:0]] : memArr[eAddr[7:0]];
    end
    checkOutput("cpu_stall", 32'(sbIf.cpu_stall), 32'(eStall));
    checkOutput("mem_read",  32'(sbIf.mem_read),  32'(eMr));
    checkOutput("mem_write", 32'(sbIf.mem_write), 32'(eMw));
    checkOutput("mem_addr",  sbIf.mem_addr,  eAddr);
    checkOutput("mem_wdata", sbIf.mem_wdata, eWdata);
    checkOutput("cpu_rdata", sbIf.cpu_rdata, eRdata);
    checkOutput("count", 32'(sbIf.count), 32'(q.size()));
    checkOutput("full",  32'(sbIf.full),  32'(q.size() == DEPTH));
    checkOutput("empty", 32'(sbIf.empty), 32'(q.size() == 0));
    if (rst === 1'b1) begin
      if (mPop) begin
        expMem[q[0].a[7:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (mEnq) q.push_back('{a: sbIf.cpu_addr, d: sbIf.cpu_wdata});
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      memArr[i] = 32'd0;
      expMem[i] = 32'd0;
    end
    rst = 1'b0;
    sbIf.cpu_read  = 1'b1;
    sbIf.cpu_write = 1'b0;
    sbIf.cpu_addr  = 32'h40;
    sbIf.cpu_wdata = 32'd0;

    // Reset state, with a load held to confirm it is blocked.
    #12;
    checkOutput("rst_mem_read", 32'(sbIf.mem_read), 32'd0);
    checkOutput("rst_stall", 32'(sbIf.cpu_stall), 32'd0);
    checkOutput("rst_count", 32'(sbIf.count), 32'd0);
    checkOutput("rst_empty", 32'(sbIf.empty), 32'd1);
    checkOutput("rst_full",  32'(sbIf.full),  32'd0);
    sbIf.cpu_read = 1'b0;
    @(posedge clk); #1; rst = 1'b1;

    // Two stores, then two idle drains in FIFO order.
    applyStimulus(0, 1, 32'h10, 32'h11);
    applyStimulus(0, 1, 32'h14, 32'h22);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("two_count", 32'(sbIf.count), 32'd2);
    checkOutput("drain1_we", 32'(sbIf.mem_write), 32'd1);
    checkOutput("drain1_addr", sbIf.mem_addr, 32'h10);
    checkOutput("drain1_data", sbIf.mem_wdata, 32'h11);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("drain2_addr", sbIf.mem_addr, 32'h14);
    checkOutput("drain2_data", sbIf.mem_wdata, 32'h22);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("drained_empty", 32'(sbIf.empty), 32'd1);
    checkOutput("drained_we", 32'(sbIf.mem_write), 32'd0);

    // Fill to DEPTH, fifth store stalls until one idle drain.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(0, 1, 32'h40 + 32'(4 * i), 32'(i + 1));
    applyStimulus(0, 1, 32'h50, 32'h5);
    checkOutput("full_flag", 32'(sbIf.full), 32'd1);
    checkOutput("full_stall", 32'(sbIf.cpu_stall), 32'd1);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("full_drain_addr", sbIf.mem_addr, 32'h40);
    applyStimulus(0, 1, 32'h50, 32'h5);
    checkOutput("retry_stall", 32'(sbIf.cpu_stall), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("fill_empty", 32'(sbIf.empty), 32'd1);

`ifdef STORE_BUFFER_FWD_EN
    applyStimulus(0, 1, 32'h20, 32'hA);
    applyStimulus(0, 1, 32'h20, 32'hB);
    applyStimulus(1, 0, 32'h20, 32'h0);
    checkOutput("fwd_rdata", sbIf.cpu_rdata, 32'hB);
    checkOutput("fwd_mem_read", 32'(sbIf.mem_read), 32'd0);
    checkOutput("fwd_stall", 32'(sbIf.cpu_stall), 32'd0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 32'h0, 32'h0);
`else
    applyStimulus(0, 1, 32'h30, 32'h5);
    applyStimulus(1, 0, 32'h30, 32'h0);
    checkOutput("hit_stall", 32'(sbIf.cpu_stall), 32'd1);
    checkOutput("hit_we", 32'(sbIf.mem_write), 32'd1);
    checkOutput("hit_addr", sbIf.mem_addr, 32'h30);
    applyStimulus(1, 0, 32'h30, 32'h0);
    checkOutput("hit_after_stall", 32'(sbIf.cpu_stall), 32'd0);
    checkOutput("hit_after_rd", 32'(sbIf.mem_read), 32'd1);
    checkOutput("hit_after_rdata", sbIf.cpu_rdata, 32'h5);
`endif

    // Reset pulse between edges with three stores buffered.
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 32'h60 + 32'(4 * i), 32'h600 + 32'(i));
    @(posedge clk); #1;
    sbIf.cpu_write = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("pulse_count", 32'(sbIf.count), 32'd0);
    checkOutput("pulse_empty", 32'(sbIf.empty), 32'd1);
    #1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h0, 32'h0);
      checkOutput("post_pulse_we", 32'(sbIf.mem_write), 32'd0);
    end

    // Twenty stores wrapping the pointers, idles interleaved.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 32'h80 + 32'(4 * (i % 6)), 32'h1000 + 32'(i));
      if (i % 2 == 1) begin
        applyStimulus(0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 32'h0);
    for (int a = 32'h80; a < 32'h98; a += 4)
      checkOutput("mem_contents", memArr[a], expMem[a]);
    checkOutput("mem_0x80", memArr[8'h80], 32'h1012);

    // Read together with write: only the read happens.
    applyStimulus(1, 1, 32'h84, 32'hDEAD);
    checkOutput("rw_mem_read", 32'(sbIf.mem_read), 32'd1);
    checkOutput("rw_stall", 32'(sbIf.cpu_stall), 32'd0);
    checkOutput("rw_rdata", sbIf.cpu_rdata, 32'h1013);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("rw_count", 32'(sbIf.count), 32'd0);
    applyStimulus(0, 1, 32'h90, 32'h7);
    applyStimulus(1, 1, 32'h04, 32'hBEEF);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("rw_busy_count", 32'(sbIf.count), 32'd1);
    checkOutput("rw_busy_addr", sbIf.mem_addr, 32'h90);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, errCount);
    $finish;
  end
endmodule
